// File: rtl/avalon_hpc_master_if.sv
// Signal bundle for avalon_hpc_master: command/response ports, snapshot
// controls and results, and the Avalon-MM master bus toward the hpc slave.
// The "master" modport is the block's own view; "slave" is the far side.
interface avalon_hpc_master_if;
  // Command port
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [5:0]  cmd_address;
  logic [31:0] cmd_writedata;
  // Read response
  logic        rsp_valid;
  logic [31:0] rsp_readdata;
  // Snapshot sequence
  logic        snap_start;
  logic        snap_busy;
  logic        snap_done;
  logic [31:0] snap_datctr;
  logic [31:0] snap_errctr;
  logic [31:0] snap_dutdelay;
  // Avalon-MM master
  logic [5:0]  master_address;
  logic        master_read;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [31:0] master_readdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, snap_start,
           master_readdata,
    output cmd_ready, rsp_valid, rsp_readdata, snap_busy, snap_done,
           snap_datctr, snap_errctr, snap_dutdelay,
           master_address, master_read, master_write, master_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, snap_start,
           master_readdata,
    input  cmd_ready, rsp_valid, rsp_readdata, snap_busy, snap_done,
           snap_datctr, snap_errctr, snap_dutdelay,
           master_address, master_read, master_write, master_writedata
  );
endinterface

// File: rtl/avalon_hpc_master.sv
// Avalon-MM master for the hpc register slave. Executes one read or write
// command at a time and can autonomously snapshot three status registers
// (data counter, error counter, DUT delay) into holding registers.
// Strobes are decoded from the state, so each lasts exactly one cycle and
// address/writedata are zero whenever no strobe is active.
module avalon_hpc_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [5:0]  SNAP_ADDR0   = 6'h04,
  parameter logic [5:0]  SNAP_ADDR1   = 6'h08,
  parameter logic [5:0]  SNAP_ADDR2   = 6'h10
) (
  input logic                 clk,
  input logic                 reset,
  avalon_hpc_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RWAIT,
    S_SNAP_RD,
    S_SNAP_WAIT
  } state_e;

  // Wait cycles after the read strobe before readdata is valid.
  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_q;
  logic [31:0] snap_datctr_q, snap_errctr_q, snap_dutdelay_q;
  logic        snap_done_q, snap_done_d;
  logic        snap_cap;
  logic        rsp_fire;
  logic [5:0]  snap_addr;

  // Select the snapshot address for the current sequence index.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    snap_addr = SNAP_ADDR2;
    case (idx_q)
      2'd0:    snap_addr = SNAP_ADDR0;
      2'd1:    snap_addr = SNAP_ADDR1;
      default: snap_addr = SNAP_ADDR2;
    endcase
  end

  // Next-state and bus outputs for command and snapshot sequencing.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    snap_done_d = 1'b0;
    snap_cap    = 1'b0;
    rsp_fire    = 1'b0;

    bus.cmd_ready        = 1'b0;
    bus.snap_busy        = 1'b0;
    bus.master_read      = 1'b0;
    bus.master_write     = 1'b0;
    bus.master_address   = 6'd0;
    bus.master_writedata = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        // Snapshot wins over a simultaneous command; reset also blocks acceptance.
        bus.cmd_ready = ~bus.snap_start & ~reset;
        if (bus.snap_start) begin
          idx_d   = 2'd0;
          state_d = S_SNAP_RD;
        end else if (bus.cmd_valid) begin
          addr_d  = bus.cmd_address;
          wdata_d = bus.cmd_writedata;
          state_d = bus.cmd_write ? S_WR : S_RD;
        end
      end
      S_WR: begin
        bus.master_write     = 1'b1;
        bus.master_address   = addr_q;
        bus.master_writedata = wdata_q;
        state_d              = S_IDLE;
      end
      S_RD: begin
        bus.master_read    = 1'b1;
        bus.master_address = addr_q;
        cnt_d              = LAT_M1;
        state_d            = S_RWAIT;
      end
      S_RWAIT: begin
        if (cnt_q == 2'd0) begin
          // A reset landing on the capture cycle discards the result.
          rsp_fire = ~reset;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_SNAP_RD: begin
        bus.snap_busy      = 1'b1;
        bus.master_read    = 1'b1;
        bus.master_address = snap_addr;
        cnt_d              = LAT_M1;
        state_d            = S_SNAP_WAIT;
      end
      S_SNAP_WAIT: begin
        bus.snap_busy = 1'b1;
        if (cnt_q == 2'd0) begin
          snap_cap = 1'b1;
          if (idx_q == 2'd2) begin
            snap_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SNAP_RD;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read data is forwarded on the capture cycle, then held from rsp_q.
    bus.rsp_valid    = rsp_fire;
    bus.rsp_readdata = rsp_fire ? bus.master_readdata : rsp_q;
  end

  // State, latched command, response and snapshot holding registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q         <= S_IDLE;
      idx_q           <= 2'd0;
      cnt_q           <= 2'd0;
      addr_q          <= 6'd0;
      wdata_q         <= 32'd0;
      rsp_q           <= 32'd0;
      snap_datctr_q   <= 32'd0;
      snap_errctr_q   <= 32'd0;
      snap_dutdelay_q <= 32'd0;
      snap_done_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      snap_done_q <= snap_done_d;
      if (rsp_fire) rsp_q <= bus.master_readdata;
      if (snap_cap && idx_q == 2'd0) snap_datctr_q   <= bus.master_readdata;
      if (snap_cap && idx_q == 2'd1) snap_errctr_q   <= bus.master_readdata;
      if (snap_cap && idx_q == 2'd2) snap_dutdelay_q <= bus.master_readdata;
    end
  end

  assign bus.snap_done     = snap_done_q;
  assign bus.snap_datctr   = snap_datctr_q;
  assign bus.snap_errctr   = snap_errctr_q;
  assign bus.snap_dutdelay = snap_dutdelay_q;

endmodule

// File: tb/tb_avalon_hpc_master.sv
// Bench for avalon_hpc_master: a READ_LATENCY=1 instance against a small
// register-slave model and a READ_LATENCY=3 instance for latency timing.
// Expected read data is queued when a read is issued and compared when
// rsp_valid appears; bus invariants are monitored every cycle.
module tb_avalon_hpc_master;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_hpc_master_if bus ();
  avalon_hpc_master_if bus3 ();

  avalon_hpc_master #(.READ_LATENCY(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  avalon_hpc_master #(.READ_LATENCY(3)) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model, latency 1 ----------------
  logic [31:0] reg0_q;
  logic [31:0] rd1_q;

  function automatic logic [31:0] slave_rd(input logic [5:0] a, input logic [31:0] r0);
    case (a)
      6'h00:   return r0;
      6'h04:   return 32'd123;
      6'h08:   return 32'd4;
      6'h0C:   return 32'd20;
      6'h10:   return 32'd7;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) reg0_q <= 32'd0;
    else if (bus.master_write && bus.master_address == 6'h00) reg0_q <= bus.master_writedata;
    rd1_q <= bus.master_read ? slave_rd(bus.master_address, reg0_q) : 32'hBAD0_0001;
  end
  assign bus.master_readdata = rd1_q;

  // ---------------- slave model, latency 3 ----------------
  logic [31:0] p0_q, p1_q, p2_q;
  always @(posedge clk) begin
    p0_q <= bus3.master_read ? (32'hC0DE_0000 | {26'd0, bus3.master_address}) : 32'hBAD0_0003;
    p1_q <= p0_q;
    p2_q <= p1_q;
  end
  assign bus3.master_readdata = p2_q;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // ---------------- monitors ----------------
  logic [31:0] exp_q[$];
  logic [5:0]  rd_addr_log[$];
  int          rd_cyc_log[$];
  int          rsp_count   = 0;
  int          rsp_cyc     = 0;
  int          busy_cycles = 0;
  logic        prev_strobe = 1'b0;
  int          rsp3_count  = 0;
  int          rsp3_cyc    = 0;
  logic [31:0] rsp3_data   = 32'd0;

  // Bus invariants, read log and response scoreboard for the latency-1 DUT.
  always @(negedge clk) begin
    if (!reset) begin
      check_bit("rd_wr_exclusive", bus.master_read & bus.master_write, 1'b0);
      check_bit("strobe_single_cycle", prev_strobe & (bus.master_read | bus.master_write), 1'b0);
      if (!bus.master_read && !bus.master_write) begin
        check("idle_address_zero", {26'd0, bus.master_address}, 32'd0);
        check("idle_writedata_zero", bus.master_writedata, 32'd0);
      end
      prev_strobe <= bus.master_read | bus.master_write;
      if (bus.master_read) begin
        rd_addr_log.push_back(bus.master_address);
        rd_cyc_log.push_back(cyc);
      end
      if (bus.snap_busy) busy_cycles <= busy_cycles + 1;
    end else begin
      prev_strobe <= 1'b0;
    end
    if (bus.rsp_valid) begin
      rsp_count <= rsp_count + 1;
      rsp_cyc   <= cyc;
      if (exp_q.size() == 0) check_bit("rsp_unexpected", bus.rsp_valid, 1'b0);
      else check("rsp_data", bus.rsp_readdata, exp_q.pop_front());
    end
  end

  // Response capture for the latency-3 DUT.
  always @(negedge clk) begin
    if (bus3.rsp_valid) begin
      rsp3_count <= rsp3_count + 1;
      rsp3_cyc   <= cyc;
      rsp3_data  <= bus3.rsp_readdata;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d,
                        output int hs_c);
    logic ok;
    @(negedge clk);
    bus.cmd_valid     = 1'b1;
    bus.cmd_write     = wr;
    bus.cmd_address   = a;
    bus.cmd_writedata = d;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    hs_c = cyc;
    check_bit("cmd_accepted", ok, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_write     = 1'b0;
    bus.cmd_address   = 6'd0;
    bus.cmd_writedata = 32'd0;
  endtask

  task automatic wait_rsp(input int n0);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (rsp_count != n0) begin
        seen = 1'b1;
        break;
      end
    end
    check_bit("rsp_arrived", seen, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   hs, hs3, n0, b0, l0;
    logic done_seen;

    bus.cmd_valid      = 1'b0;
    bus.cmd_write      = 1'b0;
    bus.cmd_address    = 6'd0;
    bus.cmd_writedata  = 32'd0;
    bus.snap_start     = 1'b0;
    bus3.cmd_valid     = 1'b0;
    bus3.cmd_write     = 1'b0;
    bus3.cmd_address   = 6'd0;
    bus3.cmd_writedata = 32'd0;
    bus3.snap_start    = 1'b0;

    // Reset state
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_bit("reset_cmd_ready", bus.cmd_ready, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_bit("idle_cmd_ready", bus.cmd_ready, 1'b1);
    check_bit("idle_rsp_valid", bus.rsp_valid, 1'b0);
    check_bit("idle_snap_busy", bus.snap_busy, 1'b0);
    check_bit("idle_snap_done", bus.snap_done, 1'b0);
    check("idle_snap_datctr", bus.snap_datctr, 32'd0);
    check("idle_snap_errctr", bus.snap_errctr, 32'd0);
    check("idle_snap_dutdelay", bus.snap_dutdelay, 32'd0);
    check("idle_rsp_readdata", bus.rsp_readdata, 32'd0);

    // Write addr 0x00 = 6: one write strobe with latched address/data
    do_cmd(1'b1, 6'h00, 32'h0000_0006, hs);
    @(negedge clk);
    check_bit("wr_strobe", bus.master_write, 1'b1);
    check_bit("wr_no_read", bus.master_read, 1'b0);
    check("wr_address", {26'd0, bus.master_address}, 32'h0000_0000);
    check("wr_writedata", bus.master_writedata, 32'h0000_0006);
    @(negedge clk);
    check_bit("wr_strobe_dropped", bus.master_write, 1'b0);

    // Read back addr 0x00
    n0 = rsp_count;
    exp_q.push_back(32'h0000_0006);
    do_cmd(1'b0, 6'h00, 32'd0, hs);
    wait_rsp(n0);
    check("rd0_latency", 32'(rsp_cyc - hs), 32'd2);
    repeat (3) @(negedge clk);
    #2;
    check("rd0_single_pulse", 32'(rsp_count - n0), 32'd1);
    check("rd0_data_held", bus.rsp_readdata, 32'h0000_0006);

    // Sysver read at 0x0C
    n0 = rsp_count;
    exp_q.push_back(32'd20);
    do_cmd(1'b0, 6'h0C, 32'd0, hs);
    wait_rsp(n0);
    check("sysver_latency", 32'(rsp_cyc - hs), 32'd2);
    repeat (3) @(negedge clk);
    #2;
    check("sysver_single_pulse", 32'(rsp_count - n0), 32'd1);

    // Snapshot with a simultaneous read command: snapshot first
    n0 = rsp_count;
    b0 = busy_cycles;
    l0 = rd_addr_log.size();
    exp_q.push_back(32'd20);
    @(negedge clk);
    bus.snap_start    = 1'b1;
    bus.cmd_valid     = 1'b1;
    bus.cmd_write     = 1'b0;
    bus.cmd_address   = 6'h0C;
    #1;
    check_bit("prio_cmd_ready", bus.cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.snap_start = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus.snap_done) begin
        done_seen = 1'b1;
        break;
      end
      check_bit("busy_cmd_ready", bus.cmd_ready, 1'b0);
    end
    check_bit("snap_done_seen", done_seen, 1'b1);
    check("snap_datctr", bus.snap_datctr, 32'd123);
    check("snap_errctr", bus.snap_errctr, 32'd4);
    check("snap_dutdelay", bus.snap_dutdelay, 32'd7);
    check_bit("snap_busy_at_done", bus.snap_busy, 1'b0);
    check("snap_busy_cycles", 32'(busy_cycles - b0), 32'd6);
    check("snap_cmd_deferred", 32'(rsp_count - n0), 32'd0);
    check_bit("done_cmd_ready", bus.cmd_ready, 1'b1);
    hs = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_address = 6'd0;
    @(negedge clk);
    #1;
    check_bit("snap_done_one_cycle", bus.snap_done, 1'b0);
    wait_rsp(n0);
    check("deferred_rd_latency", 32'(rsp_cyc - hs), 32'd2);
    check("snap_read_count", 32'(rd_addr_log.size() - l0), 32'd4);
    if (rd_addr_log.size() >= l0 + 4) begin
      check("snap_addr0", {26'd0, rd_addr_log[l0]},     32'h04);
      check("snap_addr1", {26'd0, rd_addr_log[l0 + 1]}, 32'h08);
      check("snap_addr2", {26'd0, rd_addr_log[l0 + 2]}, 32'h10);
      check("deferred_addr", {26'd0, rd_addr_log[l0 + 3]}, 32'h0C);
      check("snap_gap01", 32'(rd_cyc_log[l0 + 1] - rd_cyc_log[l0]), 32'd2);
      check("snap_gap12", 32'(rd_cyc_log[l0 + 2] - rd_cyc_log[l0 + 1]), 32'd2);
    end

    // Reset during RWAIT: result discarded, everything cleared
    n0 = rsp_count;
    do_cmd(1'b0, 6'h04, 32'd0, hs);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_bit("rst_no_rsp", bus.rsp_valid, 1'b0);
    @(negedge clk);
    #1;
    check_bit("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check_bit("rst_read", bus.master_read, 1'b0);
    check_bit("rst_write", bus.master_write, 1'b0);
    check("rst_address", {26'd0, bus.master_address}, 32'd0);
    check("rst_writedata", bus.master_writedata, 32'd0);
    check_bit("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_readdata", bus.rsp_readdata, 32'd0);
    check_bit("rst_snap_busy", bus.snap_busy, 1'b0);
    check_bit("rst_snap_done", bus.snap_done, 1'b0);
    check("rst_snap_datctr", bus.snap_datctr, 32'd0);
    check("rst_snap_errctr", bus.snap_errctr, 32'd0);
    check("rst_snap_dutdelay", bus.snap_dutdelay, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_bit("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_rsp_suppressed", 32'(rsp_count - n0), 32'd0);

    // READ_LATENCY = 3 instance: read 0x04
    @(negedge clk);
    bus3.cmd_valid   = 1'b1;
    bus3.cmd_write   = 1'b0;
    bus3.cmd_address = 6'h04;
    #1;
    check_bit("l3_cmd_ready", bus3.cmd_ready, 1'b1);
    hs3 = cyc;
    @(posedge clk);
    #1;
    bus3.cmd_valid   = 1'b0;
    bus3.cmd_address = 6'd0;
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (rsp3_count != 0) begin
        done_seen = 1'b1;
        break;
      end
    end
    check_bit("l3_rsp_arrived", done_seen, 1'b1);
    check("l3_latency", 32'(rsp3_cyc - hs3), 32'd4);
    check("l3_data", rsp3_data, 32'hC0DE_0004);
    repeat (4) @(negedge clk);
    #2;
    check("l3_single_pulse", 32'(rsp3_count), 32'd1);
    check("l3_data_held", bus3.rsp_readdata, 32'hC0DE_0004);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time limit in case a bounded wait is bypassed
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
